// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: default word size, bit-counter sizing, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

  localparam int WORD_W_DEFAULT = 32;

  // Width of a counter that must hold 0 .. w-1 (never narrower than one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit, with a selectable reset value.
// Latency: DEPTH clk cycles from input to q.
// Backpressure: none; samples every cycle.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stg;

  // Shift the raw input through DEPTH flops; the last stage is the clean copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg <= {DEPTH{RST_VAL}};
    end else begin
      stg <= {stg[DEPTH-2:0], d};
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled sck/ss/mosi, MSB-first word rx/tx; optional frame_err via SPI_SLAVE_FRAME_ERR_EN.
// Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the clk edge that first registers the last sck rise.
// Backpressure: none; rx_data is overwritten per word and tx_data is taken on each tx_load pulse.
module spi_slave import spi_pkg::*; #(
  parameter int WORD_W      = WORD_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck_in,
  input  logic              ss_in,
  input  logic              mosi,
  output logic              miso,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [WORD_W-1:0] tx_data,
  output logic              tx_load,
  output logic              active
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  // A single-flop "synchronizer" is not metastability-safe, so never go below two.
  localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_W = cnt_width(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic sck_s, ss_s, mosi_s;
  logic sck_d, ss_d;
  logic sck_rise, sck_fall, ss_rise, ss_fall;

  state_t state, state_nxt;
  logic   enter, leave, rx_shift_en, tx_shift_en, tx_reload;

  logic [CNT_W-1:0]  rx_cnt, tx_cnt;
  logic [WORD_W-1:0] rx_shift, tx_shift;
  logic              word_done, rx_commit;

  sync_ff #(.DEPTH(DEPTH), .RST_VAL(1'b0)) u_sync_sck (.clk(clk), .rst(reset), .d(sck_in), .q(sck_s));
  sync_ff #(.DEPTH(DEPTH), .RST_VAL(1'b1)) u_sync_ss  (.clk(clk), .rst(reset), .d(ss_in),  .q(ss_s));
  sync_ff #(.DEPTH(DEPTH), .RST_VAL(1'b0)) u_sync_mosi(.clk(clk), .rst(reset), .d(mosi),   .q(mosi_s));

  // One more registered copy of sck/ss so edges show up as single-cycle strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_d <= 1'b0;
      ss_d  <= 1'b1;
    end else begin
      sck_d <= sck_s;
      ss_d  <= ss_s;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_fall  = ~ss_s & ss_d;
  assign ss_rise  = ss_s & ~ss_d;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle strobes; an ss rise pre-empts any sck edge seen in the same cycle.
  always_comb begin
    state_nxt   = state;
    tx_load     = 1'b0;
    enter       = 1'b0;
    leave       = 1'b0;
    rx_shift_en = 1'b0;
    tx_shift_en = 1'b0;
    tx_reload   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = SHIFT;
          enter     = 1'b1;
          tx_load   = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_nxt = IDLE;
          leave     = 1'b1;
        end else begin
          rx_shift_en = sck_rise;
          if (sck_fall) begin
            if (tx_cnt == LAST_BIT) begin
              tx_reload = 1'b1;
              tx_load   = 1'b1;
            end else begin
              tx_shift_en = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers, bit counters and the word-complete pipeline
  // (shift completes -> rx_data written -> rx_valid pulses, one cycle apart each).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt    <= '0;
      tx_cnt    <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      word_done <= 1'b0;
      rx_commit <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      word_done <= 1'b0;
      rx_commit <= word_done;
      rx_valid  <= rx_commit;
      if (word_done) begin
        rx_data <= rx_shift;
      end
      if (enter) begin
        rx_cnt   <= '0;
        tx_cnt   <= '0;
        tx_shift <= tx_data;
      end
      // Partial bits are dropped simply by restarting the count on the next frame.
      if (leave) begin
        rx_cnt <= '0;
      end
      if (rx_shift_en) begin
        rx_shift <= {rx_shift[WORD_W-2:0], mosi_s};
        if (rx_cnt == LAST_BIT) begin
          rx_cnt    <= '0;
          word_done <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + CNT_W'(1);
        end
      end
      if (tx_reload) begin
        tx_shift <= tx_data;
        tx_cnt   <= '0;
      end else if (tx_shift_en) begin
        tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
        tx_cnt   <= tx_cnt + CNT_W'(1);
      end
    end
  end

  assign miso   = (state == SHIFT) ? tx_shift[WORD_W-1] : 1'b0;
  assign active = (state == SHIFT);

`ifdef SPI_SLAVE_FRAME_ERR_EN
  // Flag a frame that ends with a partially received word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= leave && (rx_cnt != '0);
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam int W    = 32;
  localparam int S    = 2;
  localparam int HALF = 6;

  logic         clk = 1'b0;
  logic         reset, sck_in, ss_in, mosi;
  logic         miso, rx_valid, tx_load, active;
  logic [W-1:0] rx_data, tx_data;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic         frame_err;
  int           fe_cnt = 0;
`endif

  int checks = 0;
  int failures = 0;
  int tl_cnt = 0;
  int rv_stretch = 0;
  logic rv_prev = 1'b0;

  logic [W-1:0] got_rx[$], exp_rx[$], got_mi[$], exp_mi[$];
  logic [W-1:0] mo_w[4];
  logic [W-1:0] tx_w[4];
  logic [W-1:0] last_rx = '0;

  spi_slave #(.WORD_W(W), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .sck_in   (sck_in),
    .ss_in    (ss_in),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .active   (active)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Observe the DUT mid-cycle: collect received words and count pulses.
  always @(negedge clk) begin
    if (tx_load) tl_cnt++;
    if (rx_valid) got_rx.push_back(rx_data);
    if (rx_valid && rv_prev) rv_stretch++;
    rv_prev = rx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (frame_err) fe_cnt++;
`endif
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // SPI mode-0 master. The final sck fall and the ss rise happen together.
  // rst_at >= 0 asserts reset before that bit index; lat measures rx_valid timing on the last rise.
  task automatic frame(input int nw, input int nbits, input int rst_at, input bit lat);
    logic [W-1:0] m;
    int k, i;
    m = '0;
    tx_data = tx_w[0];
    cycles(2);
    ss_in = 1'b0;
    cycles(8);
    for (int b = 0; b < nbits; b++) begin
      k = b / W;
      i = b % W;
      mosi = mo_w[k][W-1-i];
      if (i == W-1) tx_data = (k + 1 < nw) ? tx_w[k+1] : W'($urandom);
      if (b == rst_at) begin
        reset  = 1'b1;
        sck_in = 1'b0;
        ss_in  = 1'b1;
        cycles(2);
        chk("rstmid:miso",     W'(miso),     W'(0));
        chk("rstmid:rx_valid", W'(rx_valid), W'(0));
        chk("rstmid:rx_data",  rx_data,      W'(0));
        chk("rstmid:tx_load",  W'(tx_load),  W'(0));
        chk("rstmid:active",   W'(active),   W'(0));
        reset = 1'b0;
        cycles(4);
        return;
      end
      cycles(HALF);
      m = {m[W-2:0], miso};
      sck_in = 1'b1;
      if (lat && b == nbits - 1) begin
        @(posedge clk);
        repeat (S + 1) @(posedge clk);
        #1 chk("lat:before", W'(rx_valid), W'(0));
        @(posedge clk);
        #1 chk("lat:at",     W'(rx_valid), W'(1));
        cycles(HALF - S - 2);
      end else begin
        cycles(HALF);
      end
      sck_in = 1'b0;
      if (b == nbits - 1) ss_in = 1'b1;
      if (i == W-1) got_mi.push_back(m);
    end
    cycles(3 * HALF);
  endtask

  // Run one frame and compare against the word-level model.
  task automatic run(input string tag, input int nw, input int nbits, input int rst_at, input bit lat);
    int tl0, full, el;
    tl0  = tl_cnt;
    full = ((rst_at >= 0) ? rst_at : nbits) / W;
    el   = (rst_at >= 0) ? 1 : 1 + (nbits - 1) / W;
    frame(nw, nbits, rst_at, lat);
    for (int k = 0; k < full; k++) begin
      exp_rx.push_back(mo_w[k]);
      exp_mi.push_back(tx_w[k]);
    end
    if (full > 0) last_rx = mo_w[full-1];
    if (rst_at >= 0) last_rx = '0;
    chk({tag, ":rx_n"}, W'(got_rx.size()), W'(exp_rx.size()));
    while (got_rx.size() > 0 && exp_rx.size() > 0) chk({tag, ":rx"}, got_rx.pop_front(), exp_rx.pop_front());
    chk({tag, ":miso_n"}, W'(got_mi.size()), W'(exp_mi.size()));
    while (got_mi.size() > 0 && exp_mi.size() > 0) chk({tag, ":miso"}, got_mi.pop_front(), exp_mi.pop_front());
    got_rx.delete(); exp_rx.delete(); got_mi.delete(); exp_mi.delete();
    chk({tag, ":tx_loads"}, W'(tl_cnt - tl0), W'(el));
    chk({tag, ":active"},   W'(active),       W'(0));
  endtask

  initial begin
    int fe0;
    reset = 1'b1; sck_in = 1'b0; ss_in = 1'b1; mosi = 1'b0; tx_data = '0;
    cycles(3);
    chk("reset:miso",     W'(miso),     W'(0));
    chk("reset:rx_valid", W'(rx_valid), W'(0));
    chk("reset:rx_data",  rx_data,      W'(0));
    chk("reset:tx_load",  W'(tx_load),  W'(0));
    chk("reset:active",   W'(active),   W'(0));
    reset = 1'b0;
    cycles(3);

    // sck activity while deselected must be ignored
    for (int t = 0; t < 6; t++) begin
      mosi   = 1'($urandom);
      sck_in = ~sck_in;
      cycles(HALF);
    end
    cycles(10);
    chk("idle:rx_n",    W'(got_rx.size()), W'(0));
    chk("idle:tx_load", W'(tl_cnt),        W'(0));
    chk("idle:active",  W'(active),        W'(0));
    chk("idle:miso",    W'(miso),          W'(0));

    mo_w[0] = 32'hDEADBEEF; tx_w[0] = 32'hA5A5A5A5;
    run("single", 1, 32, -1, 1'b0);

    mo_w[0] = 32'h00000003; mo_w[1] = 32'h12345678; mo_w[2] = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) tx_w[k] = $urandom;
    run("b2b", 3, 96, -1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      mo_w[k] = $urandom;
      tx_w[k] = $urandom;
    end
    run("rand", 4, 128, -1, 1'b0);

`ifdef SPI_SLAVE_FRAME_ERR_EN
    fe0 = fe_cnt;
`else
    fe0 = 0;
`endif
    mo_w[0] = 32'hCAFEF00D; tx_w[0] = $urandom;
    run("abort", 1, 17, -1, 1'b0);
    chk("abort:rx_data", rx_data, last_rx);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("abort:frame_err", W'(fe_cnt - fe0), W'(1));
`endif

    mo_w[0] = $urandom; tx_w[0] = $urandom;
    run("rstmid", 1, 32, 10, 1'b0);
    chk("rstmid:rx_after", rx_data, last_rx);
    mo_w[0] = 32'h0000002A; tx_w[0] = $urandom;
    run("after_rst", 1, 32, -1, 1'b0);

    mo_w[0] = $urandom; tx_w[0] = $urandom;
    run("lat", 1, 32, -1, 1'b1);

    chk("rx_valid_width", W'(rv_stretch), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter WORD_W, default 32: bits per SPI word.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on sck_in, ss_in and mosi; minimum 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sck_in  input  1  SPI serial clock from the master; idle low.
REQ-006 ss_in  input  1  slave select, active low.
REQ-007 mosi  input  1  serial data in, MSB first.
REQ-008 miso  output  1  serial data out, MSB first.
REQ-009 rx_data  output  WORD_W  last complete received word.
REQ-010 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-011 tx_data  input  WORD_W  next word to transmit; sampled on tx_load.
REQ-012 tx_load  output  1  one-cycle pulse; tx_data captured this cycle.
REQ-013 active  output  1  high while in SHIFT state.

Function
REQ-014 sck_in, ss_in and mosi shall each pass through a SYNC_STAGES-flop synchronizer; edges are detected by comparing the last synchronizer stage with one further registered copy.
REQ-015 FSM states: IDLE (ss high) and SHIFT (ss low); IDLE->SHIFT on detected ss fall; SHIFT->IDLE on detected ss rise.
REQ-016 On entering SHIFT: rx bit count = 0, tx bit count = 0, tx shift register loads tx_data, tx_load pulses for that cycle.
REQ-017 SPI mode 0: mosi is sampled on each detected sck rise; miso changes on each detected sck fall.
REQ-018 Each sampled bit shifts into the LSB of the rx shift register.
REQ-019 On the WORD_W-th sampled bit: rx_data shall take the completed word and rx_valid shall pulse on the next cycle; rx count wraps to 0; ss may stay low for back-to-back words.
REQ-020 Latency: rx_valid high exactly SYNC_STAGES+2 clk cycles after the clk edge that first registers the WORD_W-th sck rise.
REQ-021 On each sck fall, the tx register shifts left; on the WORD_W-th fall it reloads tx_data, pulses tx_load and wraps tx count to 0.
REQ-022 miso = MSB of tx register in SHIFT; miso = 0 in IDLE.
REQ-023 No backpressure: rx_data is overwritten on each completed word, and rx_valid is never stretched.
REQ-024 On ss rise mid-word, partial rx bits shall be discarded; rx_data and rx_valid are unaffected.
REQ-025 sck edges detected in IDLE shall be ignored.
REQ-026 If an ss rise and an sck edge are detected in the same cycle, the ss rise wins and the bit is dropped.
REQ-027 Master timing constraints: sck high and low each at least SYNC_STAGES+1 clk periods; at least SYNC_STAGES+2 clk periods from ss fall to the first sck rise.

Reset
REQ-028 Reset shall set: state IDLE, counters 0, shift registers 0, synchronizers 1 for ss and 0 for sck/mosi, rx_data 0, and rx_valid, tx_load, active and miso all 0.
REQ-029 Reset asserted mid-word shall abandon the word with no rx_valid; after release the block waits in IDLE for a fresh ss fall.

Configuration
REQ-030 Macro SPI_SLAVE_FRAME_ERR_EN: when defined, adds output frame_err (1 bit), which pulses one cycle on an ss rise with rx count nonzero; it resets to 0.
REQ-031 Without SPI_SLAVE_FRAME_ERR_EN, the port and its logic are absent and all other behaviour is identical.

Structure
REQ-032 Package spi_pkg shall hold the WORD_W default, the bit-count width function/constant, and the FSM state enum (IDLE, SHIFT).
REQ-033 One sub-module, sync_ff (parameterized depth, reset value), shall be instantiated three times for the synchronizers.

Verification
REQ-034 Single word: ss low, send 0xDEADBEEF with tx_data=0xA5A5A5A5 -> one rx_valid, rx_data=0xDEADBEEF, master receives 0xA5A5A5A5, exactly one tx_load at ss fall.
REQ-035 Back-to-back: ss held low, send 0x00000003, 0x12345678, 0xFFFFFFFF -> three rx_valid in order with matching rx_data; tx_load at ss fall and after bits 32 and 64.
REQ-036 Abort: ss rises after 17 bits of 0xCAFEF00D -> no rx_valid, rx_data unchanged, frame_err pulses once (macro on), active drops.
REQ-037 Reset mid-word: assert reset after 10 bits, release, send 0x0000002A -> all outputs 0 during reset, single rx_valid with 0x0000002A afterwards.
REQ-038 Latency/IDLE: toggle sck with ss high -> no rx_valid or tx_load; then measure rx_valid at exactly SYNC_STAGES+2 cycles after the 32nd sck rise.
